lt24_pixel_writer: RTL
======================

// Module: lt24_pixel_writer
// PURPOSE
//  Sink end of the pixel interface (xAddr/yAddr/pixelData, pixelWrite/pixelReady) used by game logic.
//  Accepts one pixel per handshake and emits ILI9341 8080-style write cycles on the LT24 bus.
//  Sends the window/address commands only when the pixel is not the address-auto-increment successor.
//  Sits between the game/render FSM and the LT24 pins; panel power-up init is out of scope.
// PARAMETERS
//  WIDTH    240  panel columns; xAddr valid range 0..WIDTH-1
//  HEIGHT   320  panel rows; yAddr valid range 0..HEIGHT-1
//  WR_LOW   2    clocks LT24Wr_n held low per bus word (>=1)
//  WR_HIGH  2    clocks LT24Wr_n held high after each word (>=1)
// PORTS
//  clock        in   1   system clock (50 MHz)
//  reset_n      in   1   asynchronous, active-low reset
//  xAddr        in   8   pixel column
//  yAddr        in   9   pixel row
//  pixelData    in   16  RGB565 colour
//  pixelWrite   in   1   request; pixel accepted on pixelWrite && pixelReady at clock edge
//  pixelReady   out  1   high when a new pixel can be accepted
//  addrError    out  1   one-cycle pulse: offered pixel out of range, dropped
//  LT24CS_n     out  1   chip select, low for whole transaction
//  LT24RS       out  1   0 = command word, 1 = data word
//  LT24Wr_n     out  1   write strobe; panel latches on rising edge
//  LT24Rd_n     out  1   constant 1
//  LT24Data     out  16  bus data; commands/address bytes in [7:0], [15:8]=0
// BEHAVIOUR
//  Reset (async): pixelReady=1, addrError=0, CS_n=1, RS=1, Wr_n=1, Rd_n=1, Data=0; expected-address invalid.
//  States: IDLE -> (ADDR -> ) PIXEL -> IDLE. pixelReady=1 only in IDLE.
//  Accept in IDLE: latch x,y,data; if x>=WIDTH or y>=HEIGHT: addrError=1 next cycle, stay IDLE, no bus activity.
//  Sequential test: hit when expected valid and (x,y)==expected; else miss.
//  Miss -> ADDR sends 11 words then pixel: RS=0 0x2A; RS=1 x[15:8],x[7:0],0x00,WIDTH-1;
//    RS=0 0x2B; RS=1 y[15:8],y[7:0],(HEIGHT-1)>>8,(HEIGHT-1)&0xFF; RS=0 0x2C.
//  Hit -> PIXEL only: one RS=1 word = pixelData (RAMWR stream continues).
//  Each word: Data/RS set on first cycle together with Wr_n=0; Wr_n low WR_LOW clocks, high WR_HIGH clocks;
//    Data/RS held stable until end of high phase.
//  CS_n falls with first word of transaction; rises in the cycle pixelReady returns to 1.
//  Latency (accept at edge T): hit -> pixelReady=1 at T+(WR_LOW+WR_HIGH)+1; miss -> T+12*(WR_LOW+WR_HIGH)+1.
//  After pixel word: expected = (x+1,y); x==WIDTH-1 -> (0,y+1); also y==HEIGHT-1 -> (0,0). expected valid=1.
//  pixelWrite while pixelReady=0: ignored, no buffering; requester holds values until accepted.
//  Inputs sampled only at accept; later changes to xAddr/yAddr/pixelData do not affect transaction.
//  reset_n low mid-transaction: bus idles immediately, transaction abandoned, next pixel is a miss.
//  Arithmetic: word counter 4 bits (0..11); phase counter $clog2(WR_LOW+WR_HIGH) bits; x/y compare unsigned.
// STRUCTURE
//  Shared package lt24_pkg: opcodes CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; RGB565 colour constants
//    (BLACK, GREEN, RED, BLUE, YELLOW) moved there from game top level.
//  Sub-module lt24_bus_cycle: takes start, rs, data; drives Wr_n/RS/Data for one word, returns done pulse
//    on last high-phase cycle. lt24_pixel_writer holds the FSM, word sequencer and expected-address logic.
// TESTING
//  1 After reset, write (0,0,16'h4DC4) -> 12 words: 2A,00,00,00,EF,2B,00,00,01,3F,2C,4DC4; RS 0,1x4,0,1x4,0,1.
//  2 Then write (1,0,16'hF920) -> single RS=1 word F920; pixelReady low exactly WR_LOW+WR_HIGH+1 cycles.
//  3 Full-frame raster 240x320 then (0,0) -> only first pixel of frame sends address; wrap to (0,0) is hit.
//  4 Write (240,5) or (3,320) -> addrError pulse 1 cycle, CS_n stays 1, pixelReady stays 1.
//  5 Write (10,10) then (50,20) -> second is miss: full 12-word sequence with x bytes 00,32 and y 00,14.
//  6 Assert reset_n low during word 6 of a miss -> CS_n=1, Wr_n=1 immediately; next (1,0) writes full address.

Source files
------------

// File: rtl/lt24_pkg.sv
// ---------------------------------------------------------------------------
// lt24_pkg
// Shared definitions for the LT24 (ILI9341, 8080-style) pixel path:
//   - ILI9341 opcodes used by the pixel writer
//   - RGB565 colour constants used by the game logic
//   - writer FSM state type and the bus-word record passed to the bus cycler
// No ports; imported with "import lt24_pkg::*;".
// ---------------------------------------------------------------------------
package lt24_pkg;

  // ILI9341 opcodes
  localparam logic [7:0] CMD_CASET = 8'h2A;  // column address set
  localparam logic [7:0] CMD_PASET = 8'h2B;  // page (row) address set
  localparam logic [7:0] CMD_RAMWR = 8'h2C;  // memory write

  // RGB565 colours
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  // Index of the pixel-data word within a full (miss) sequence of 12 words.
  localparam logic [3:0] WORD_PIXEL = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PIXEL
  } wr_state_e;

  // One word on the LT24 bus: rs=0 command, rs=1 data.
  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } bus_word_t;

  function automatic bus_word_t cmd_word(input logic [7:0] op);
    return '{rs: 1'b0, data: {8'h00, op}};
  endfunction

  function automatic bus_word_t byte_word(input logic [7:0] b);
    return '{rs: 1'b1, data: {8'h00, b}};
  endfunction

endpackage

// File: rtl/lt24_bus_cycle.sv
// ---------------------------------------------------------------------------
// lt24_bus_cycle
// Drives one 8080-style write word: on start_i, RS/Data are loaded and Wr_n
// goes low in the same cycle; Wr_n stays low WR_LOW clocks, then high
// WR_HIGH clocks, with RS/Data held until the end of the high phase.
// done_o pulses on the last high-phase cycle; a start_i in that same cycle
// launches the next word back-to-back.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        launch a word (sampled at the clock edge)
//   word_i         {rs, data} for the word being launched
//   wr_n_o         write strobe (panel latches on its rising edge)
//   rs_o, data_o   register-select and bus data, held per word
//   done_o         last cycle of the current word
// ---------------------------------------------------------------------------
module lt24_bus_cycle
  import lt24_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  bus_word_t   word_i,
  output logic        wr_n_o,
  output logic        rs_o,
  output logic [15:0] data_o,
  output logic        done_o
);

  localparam int PERIOD = WR_LOW + WR_HIGH;
  localparam int PW     = $clog2(PERIOD);
  localparam logic [PW-1:0] LOW_LAST = PW'(WR_LOW - 1);
  localparam logic [PW-1:0] LAST     = PW'(PERIOD - 1);

  logic          busy_q, busy_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          wr_n_q, wr_n_d;
  logic          rs_q, rs_d;
  logic [15:0]   data_q, data_d;

  assign done_o = busy_q && (phase_q == LAST);

  always_comb begin
    // NOTE: every _d gets its _q as a default before any branch, so no path
    // leaves a combinational variable unassigned and no latch is inferred.
    busy_d  = busy_q;
    phase_d = phase_q;
    wr_n_d  = wr_n_q;
    rs_d    = rs_q;
    data_d  = data_q;
    if (start_i) begin
      busy_d  = 1'b1;
      phase_d = '0;
      wr_n_d  = 1'b0;
      rs_d    = word_i.rs;
      data_d  = word_i.data;
    end else if (busy_q) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == LOW_LAST) wr_n_d = 1'b1;
      if (done_o) begin
        busy_d  = 1'b0;
        phase_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register in the design samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      phase_q <= '0;
      wr_n_q  <= 1'b1;
      rs_q    <= 1'b1;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      wr_n_q  <= wr_n_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign wr_n_o = wr_n_q;
  assign rs_o   = rs_q;
  assign data_o = data_q;

endmodule

// File: rtl/lt24_pixel_writer.sv
// ---------------------------------------------------------------------------
// lt24_pixel_writer
// Pixel sink for the game/render logic. Accepts one pixel per
// pixelWrite/pixelReady handshake and writes it to the ILI9341 on the LT24
// bus. When the pixel is not the panel's auto-increment successor of the
// previous one, the CASET/PASET/RAMWR window sequence is sent first.
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   xAddr[7:0], yAddr[8:0]  pixel column / row
//   pixelData[15:0]         RGB565 colour
//   pixelWrite              request; accepted when pixelReady is high
//   pixelReady              high only when idle
//   addrError               one-cycle pulse: out-of-range pixel dropped
//   LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data[15:0]  panel bus
// ---------------------------------------------------------------------------
module lt24_pixel_writer
  import lt24_pkg::*;
#(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        addrError,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic [15:0] LT24Data
);

  localparam logic [7:0] X_LAST    = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [7:0] Y_LAST_HI = {7'd0, Y_LAST[8]};

  wr_state_e   state_q, state_d;
  logic [3:0]  word_q, word_d;          // next word of the sequence to launch
  logic        launch_q, launch_d;      // first cycle after accept
  logic [7:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [15:0] pix_q, pix_d;
  logic [7:0]  exp_x_q, exp_x_d;        // auto-increment successor
  logic [8:0]  exp_y_q, exp_y_d;
  logic        exp_valid_q, exp_valid_d;
  logic        cs_n_q, cs_n_d;
  logic        addr_err_q, addr_err_d;

  logic        bus_start;
  logic        bus_done;
  bus_word_t   bus_word;
  logic        accept;
  logic        in_range;
  logic        hit;

  function automatic bus_word_t word_at(input logic [3:0]  idx,
                                        input logic [7:0]  x,
                                        input logic [8:0]  y,
                                        input logic [15:0] pix);
    case (idx)
      4'd0:    return cmd_word(CMD_CASET);
      4'd1:    return byte_word(8'h00);          // x[15:8]; column fits in 8 bits
      4'd2:    return byte_word(x);
      4'd3:    return byte_word(8'h00);
      4'd4:    return byte_word(X_LAST);
      4'd5:    return cmd_word(CMD_PASET);
      4'd6:    return byte_word({7'd0, y[8]});
      4'd7:    return byte_word(y[7:0]);
      4'd8:    return byte_word(Y_LAST_HI);
      4'd9:    return byte_word(Y_LAST[7:0]);
      4'd10:   return cmd_word(CMD_RAMWR);
      default: return '{rs: 1'b1, data: pix};
    endcase
  endfunction

  assign accept   = pixelWrite && (state_q == ST_IDLE);
  assign in_range = (xAddr <= X_LAST) && (yAddr <= Y_LAST);
  assign hit      = exp_valid_q && (xAddr == exp_x_q) && (yAddr == exp_y_q);
  assign bus_word = word_at(word_q, x_q, y_q, pix_q);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    launch_d    = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    pix_d       = pix_q;
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    exp_valid_d = exp_valid_q;
    cs_n_d      = cs_n_q;
    addr_err_d  = 1'b0;
    bus_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d   = xAddr;
          y_d   = yAddr;
          pix_d = pixelData;
          if (!in_range) begin
            addr_err_d = 1'b1;
          end else begin
            launch_d = 1'b1;
            if (hit) begin
              state_d = ST_PIXEL;
              word_d  = WORD_PIXEL;
            end else begin
              state_d = ST_ADDR;
              word_d  = 4'd0;
            end
          end
        end
      end

      // Words are chained: the next one launches in the done cycle of the
      // previous one, so the whole sequence costs one extra launch cycle.
      ST_ADDR: begin
        if (launch_q || bus_done) begin
          bus_start = 1'b1;
          if (word_q == WORD_PIXEL) state_d = ST_PIXEL;
          else                      word_d  = word_q + 4'd1;
        end
      end

      ST_PIXEL: begin
        if (launch_q) begin
          bus_start = 1'b1;
        end else if (bus_done) begin
          state_d     = ST_IDLE;
          cs_n_d      = 1'b1;
          exp_valid_d = 1'b1;
          if (x_q == X_LAST) begin
            exp_x_d = 8'd0;
            exp_y_d = (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
          end else begin
            exp_x_d = x_q + 8'd1;
            exp_y_d = y_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (bus_start) cs_n_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      word_q      <= 4'd0;
      launch_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
      exp_x_q     <= '0;
      exp_y_q     <= '0;
      exp_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      launch_q    <= launch_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      exp_x_q     <= exp_x_d;
      exp_y_q     <= exp_y_d;
      exp_valid_q <= exp_valid_d;
      cs_n_q      <= cs_n_d;
      addr_err_q  <= addr_err_d;
    end
  end

  lt24_bus_cycle #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_bus (
    .clk     (clock),
    .rst_n   (reset_n),
    .start_i (bus_start),
    .word_i  (bus_word),
    .wr_n_o  (LT24Wr_n),
    .rs_o    (LT24RS),
    .data_o  (LT24Data),
    .done_o  (bus_done)
  );

  assign pixelReady = (state_q == ST_IDLE);
  assign addrError  = addr_err_q;
  assign LT24CS_n   = cs_n_q;
  assign LT24Rd_n   = 1'b1;

endmodule
